// File: rtl/user_id_reader.sv
// ----------------------------------------------------------------------------
// user_id_reader
//   Reads the 32-bit user project ID driven by the mask-programmed constant
//   cell array. On request it samples mask_rev twice, SETTLE_CYCLES apart, and
//   only accepts the value if both samples agree. A mismatch triggers a retry.
//   After MAX_RETRY mismatches the read gives up and flags id_err. A verified ID
//   is latched into id_value. It is also streamed out MSB-first as BEAT_W-bit
//   beats on a valid/ready port.
//
// Ports
//   axis_clk, axis_rst_n : clock, async active-low reset
//   mask_rev             : static project ID from the constant-cell array
//   rd_req               : read request, only looked at while idle
//   rd_busy              : high whenever a read or stream is in progress
//   id_valid / id_value  : sticky verified ID
//   id_err               : sticky "samples never agreed" flag
//   ser_data/valid/last  : serial beat stream, ser_ready is the back-pressure
// ----------------------------------------------------------------------------
module user_id_reader #(
    parameter int SETTLE_CYCLES = 4,
    parameter int BEAT_W        = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic              axis_clk,
    input  logic              axis_rst_n,
    input  logic [31:0]       mask_rev,
    input  logic              rd_req,
    output logic              rd_busy,
    output logic              id_valid,
    output logic              id_err,
    output logic [31:0]       id_value,
    output logic [BEAT_W-1:0] ser_data,
    output logic              ser_valid,
    output logic              ser_last,
    input  logic              ser_ready
);

    localparam int NB = 32 / BEAT_W;

    if (BEAT_W != 1 && BEAT_W != 2 && BEAT_W != 4 &&
        BEAT_W != 8 && BEAT_W != 16 && BEAT_W != 32) begin : g_bad_beat_w
        $error("user_id_reader: BEAT_W must be 1, 2, 4, 8, 16 or 32");
    end
    if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("user_id_reader: SETTLE_CYCLES must be 0..255");
    end
    if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_retry
        $error("user_id_reader: MAX_RETRY must be 1..15");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE1,
        S_WAIT,
        S_SAMPLE2,
        S_SHIFT
    } state_e;

    state_e      state_q,    state_d;
    logic [31:0] s1_q,       s1_d;
    logic [7:0]  settle_q,   settle_d;
    logic [3:0]  retry_q,    retry_d;
    logic [31:0] shift_q,    shift_d;
    logic [5:0]  beat_q,     beat_d;
    logic        id_valid_q, id_valid_d;
    logic        id_err_q,   id_err_d;
    logic [31:0] id_value_q, id_value_d;

    logic        last_beat;
    logic [3:0]  retry_inc;

    assign last_beat = (beat_q == 6'(NB - 1));
    assign retry_inc = retry_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        s1_d       = s1_q;
        settle_d   = settle_q;
        retry_d    = retry_q;
        shift_d    = shift_q;
        beat_d     = beat_q;
        id_valid_d = id_valid_q;
        id_err_d   = id_err_q;
        id_value_d = id_value_q;

        unique case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    state_d    = S_SAMPLE1;
                    id_valid_d = 1'b0;
                    id_err_d   = 1'b0;
                    retry_d    = 4'd0;
                end
            end
            S_SAMPLE1: begin
                s1_d     = mask_rev;
                settle_d = 8'(SETTLE_CYCLES);
                state_d  = (SETTLE_CYCLES == 0) ? S_SAMPLE2 : S_WAIT;
            end
            S_WAIT: begin
                // Counter was loaded with SETTLE_CYCLES (>=1 here); leaving on
                // the count of 1 gives exactly SETTLE_CYCLES cycles in WAIT.
                settle_d = settle_q - 8'd1;
                if (settle_q == 8'd1) state_d = S_SAMPLE2;
            end
            S_SAMPLE2: begin
                if (mask_rev == s1_q) begin
                    id_value_d = s1_q;
                    shift_d    = s1_q;
                    id_valid_d = 1'b1;
                    beat_d     = 6'd0;
                    state_d    = S_SHIFT;
                end else begin
                    retry_d = retry_inc;
                    if (retry_inc == 4'(MAX_RETRY)) begin
                        id_err_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_SAMPLE1;
                    end
                end
            end
            S_SHIFT: begin
                if (ser_ready) begin
                    shift_d = shift_q << BEAT_W;
                    if (last_beat) begin
                        beat_d  = 6'd0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d  = beat_q + 6'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q    <= S_IDLE;
            s1_q       <= '0;
            settle_q   <= '0;
            retry_q    <= '0;
            shift_q    <= '0;
            beat_q     <= '0;
            id_valid_q <= 1'b0;
            id_err_q   <= 1'b0;
            id_value_q <= '0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            settle_q   <= settle_d;
            retry_q    <= retry_d;
            shift_q    <= shift_d;
            beat_q     <= beat_d;
            id_valid_q <= id_valid_d;
            id_err_q   <= id_err_d;
            id_value_q <= id_value_d;
        end
    end

    // Stream outputs are decoded from registered state only, so the async reset
    // drops ser_valid/rd_busy immediately without any extra flops.
    assign rd_busy   = (state_q != S_IDLE);
    assign ser_valid = (state_q == S_SHIFT);
    assign ser_last  = ser_valid && last_beat;
    assign ser_data  = shift_q[31 -: BEAT_W];
    assign id_valid  = id_valid_q;
    assign id_err    = id_err_q;
    assign id_value  = id_value_q;

endmodule

// File: doc/user_id_reader.md
Name: user_id_reader

Overview:
- Reader for the 32-bit user project ID that the mask-programmed constant-cell array drives onto mask_rev.
- On request, it samples mask_rev twice, a settle interval apart, and checks that the two samples agree.
- It latches the verified ID into a parallel readback register and streams it out MSB-first as BEAT_W-bit beats on a valid/ready serial port.
- Sits beside the ID constant array in the user project and feeds the FSIC config/readback path.

Parameters:
- SETTLE_CYCLES, 4: cycles between the first and second sample. Range 0..255; 0 skips the WAIT state.
- BEAT_W, 8: serial beat width. Legal values are 1, 2, 4, 8, 16 and 32; any other value is an elaboration error.
- MAX_RETRY, 3: sample-mismatch attempts before giving up. Range 1..15.

Ports:
- axis_clk  in  1  clock; single clock domain.
- axis_rst_n  in  1  reset, asynchronous, active-low.
- mask_rev  in  32  static project ID from the constant-cell array.
- rd_req  in  1  read request, level-sampled in IDLE only.
- rd_busy  out  1  high whenever the FSM is not in IDLE.
- id_valid  out  1  id_value holds a verified ID.
- id_err  out  1  last read failed after MAX_RETRY mismatches.
- id_value  out  32  latched verified ID.
- ser_data  out  BEAT_W  current serial beat.
- ser_valid  out  1  beat valid.
- ser_last  out  1  marks the final beat of the ID.
- ser_ready  in  1  downstream accepts the beat.

Behaviour:
- Reset (async assert, sync-to-clock deassert):
  - state = IDLE.
  - All outputs 0, including id_value.
  - retry_cnt, settle counter and shift register all 0.
- States: IDLE, SAMPLE1, WAIT, SAMPLE2, SHIFT.
- IDLE:
  - rd_req=1 at edge N → SAMPLE1 at N+1.
  - On acceptance: id_valid and id_err clear, retry_cnt clears.
- SAMPLE1:
  - s1 <= mask_rev; settle counter <= SETTLE_CYCLES.
  - Next state is WAIT, or SAMPLE2 directly if SETTLE_CYCLES=0.
- WAIT: counter decrements each cycle; exactly SETTLE_CYCLES cycles in WAIT, then SAMPLE2.
- SAMPLE2, when mask_rev == s1:
  - id_value <= s1, shift reg <= s1, id_valid <= 1.
  - → SHIFT; ser_valid rises in the same cycle id_valid rises.
  - First ser_valid is therefore at N+3+SETTLE_CYCLES.
- SAMPLE2, when mask_rev != s1:
  - retry_cnt++.
  - If the incremented count == MAX_RETRY: id_err <= 1, id_valid stays 0, → IDLE, no beats emitted.
  - Otherwise → SAMPLE1.
- SHIFT:
  - NB = 32/BEAT_W beats; ser_data = shift_reg[31 -: BEAT_W], so beat 0 is the MSBs.
  - ser_valid stays high until a ser_valid && ser_ready edge.
  - On each handshake the shift reg moves left by BEAT_W and the beat count increments.
  - ser_data and ser_last are stable while ser_valid && !ser_ready.
  - ser_last is high only with beat NB-1.
  - After the final handshake: ser_valid=0 next cycle, → IDLE.
  - BEAT_W=32: a single beat with ser_last=1.
- Back-pressure: ser_ready may stay low indefinitely; the FSM holds with no timeout.
- rd_req handling:
  - Ignored outside IDLE; no queuing.
  - If high during the final handshake cycle it is not accepted. If still high in IDLE on the next cycle it starts a new read (one IDLE cycle minimum between reads).
- id_valid / id_value are sticky after a successful read until the next accepted rd_req.
- id_err is sticky until the next accepted rd_req.
- mask_rev changing during SHIFT does not affect the beats; the stream comes from the captured shift reg.
- Reset mid-operation: all outputs return to reset values immediately (async), including dropping ser_valid mid-frame; no partial state survives.
- rd_busy = (state != IDLE), registered from state.

Test Plan:
1. Reset, mask_rev=32'hA5C3_0F71, BEAT_W=8, SETTLE=4, rd_req pulse at cycle 10, ser_ready=1:
   - rd_busy=1 at 11; ser_valid first high at 17.
   - Beats A5, C3, 0F, 71 on cycles 17-20, ser_last only on 71.
   - id_valid=1 with id_value=A5C30F71; rd_busy=0 at 21.
2. Same ID, ser_ready toggling 1,0,0,1:
   - ser_data holds through the stalls; exactly 4 handshakes, no duplicated or skipped beat.
3. mask_rev changes between SAMPLE1 and SAMPLE2 on every attempt, MAX_RETRY=3:
   - Three SAMPLE1 entries, then id_err=1, id_valid=0, no ser_valid, rd_busy=0.
   - Next rd_req with stable ID clears id_err and streams normally.
4. BEAT_W=1, ID=32'h8000_0001: 32 beats 1,0…0,1 with ser_last on beat 31. BEAT_W=32: single beat 80000001 with ser_last=1.
5. SETTLE_CYCLES=0: first ser_valid at rd_req cycle +3. rd_req held high continuously: reads back-to-back with exactly one IDLE cycle between frames.
6. axis_rst_n asserted after beat 1 of 4:
   - ser_valid, id_valid, id_value and rd_busy all go 0 asynchronously.
   - After release, a new rd_req restarts from beat 0 (MSBs).
